data_proc_hls_deadlock_reporter: RTL and testbench

- Sits directly downstream of the data_proc deadlock monitor and consumes its registered `block` output plus the raw axis block vector.
- Qualifies transient blocking against a programmable persistence threshold.
- Latches a sticky deadlock flag, a snapshot of which AXI-Stream channels were blocked, and a cycle timestamp, and raises a one-cycle interrupt pulse for the PS/debug logic.
- Keeps a saturating count of deadlock episodes.

---
 rtl/data_proc_hls_deadlock_reporter.sv | 165 ++++++++++++++++
 tb/tb_data_proc_hls_deadlock_reporter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_proc_hls_deadlock_reporter.sv
// Deadlock reporter for the data_proc HLS pipeline.
// Qualifies the monitor's registered block indication against a programmable
// persistence threshold, then latches a sticky deadlock flag, the set of
// blocked AXI-Stream channels seen during the qualifying window, and the cycle
// timestamp of the declaration. A one-cycle irq accompanies each declaration
// and a saturating counter tracks how many declarations occurred since reset.
module data_proc_hls_deadlock_reporter #(
    parameter int unsigned AXIS_W = 3,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned TS_W   = 32,
    parameter int unsigned EVT_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              block,
    input  logic [AXIS_W-1:0] axis_block_sigs,
    input  logic [CNT_W-1:0]  threshold,
    input  logic              clear,
    output logic              deadlock,
    output logic              irq,
    output logic [AXIS_W-1:0] block_snapshot,
    output logic [TS_W-1:0]   deadlock_time,
    output logic [CNT_W-1:0]  block_cycles,
    output logic [EVT_W-1:0]  event_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUSPECT,
        ST_DEADLOCK
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t              state_q,    state_d;
    logic [TS_W-1:0]     ts_q,       ts_d;
    logic [AXIS_W-1:0]   acc_q,      acc_d;
    logic [CNT_W-1:0]    cycles_q,   cycles_d;
    logic                deadlock_q, deadlock_d;
    logic                irq_q,      irq_d;
    logic [AXIS_W-1:0]   snap_q,     snap_d;
    logic [TS_W-1:0]     dtime_q,    dtime_d;
    logic [EVT_W-1:0]    evt_q,      evt_d;

    logic [CNT_W-1:0]    thr_eff;
    logic [CNT_W-1:0]    cycles_inc;
    logic [EVT_W-1:0]    evt_inc;
    logic                declare;

    // Effective threshold (zero behaves as one) and saturating increments
    always_comb begin
        thr_eff = threshold;
        if (threshold == '0) begin
            thr_eff = CNT_ONE;
        end
        cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;
        evt_inc    = (evt_q == '1)    ? evt_q    : evt_q + 1'b1;
    end

    // Next-state logic: qualification FSM, accumulator, sticky report fields
    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q + 1'b1;
        acc_d      = acc_q;
        cycles_d   = cycles_q;
        deadlock_d = deadlock_q;
        irq_d      = 1'b0;
        snap_d     = snap_q;
        dtime_d    = dtime_q;
        evt_d      = evt_q;
        declare    = 1'b0;

        if (clear) begin
            // Clear wins over everything; the block sample of this cycle is dropped
            state_d    = ST_IDLE;
            acc_d      = '0;
            cycles_d   = '0;
            deadlock_d = 1'b0;
            snap_d     = '0;
            dtime_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (block) begin
                        cycles_d = CNT_ONE;
                        acc_d    = axis_block_sigs;
                        if (CNT_ONE >= thr_eff) begin
                            declare = 1'b1;
                        end else begin
                            state_d = ST_SUSPECT;
                        end
                    end else begin
                        cycles_d = '0;
                        acc_d    = '0;
                    end
                end
                ST_SUSPECT: begin
                    if (block) begin
                        cycles_d = cycles_inc;
                        acc_d    = acc_q | axis_block_sigs;
                        // Threshold is live, so lowering it below the count declares here
                        if (cycles_inc >= thr_eff) begin
                            declare = 1'b1;
                        end
                    end else begin
                        cycles_d = '0;
                        acc_d    = '0;
                        state_d  = ST_IDLE;
                    end
                end
                ST_DEADLOCK: begin
                    cycles_d = block ? cycles_inc : '0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    cycles_d = '0;
                    acc_d    = '0;
                end
            endcase

            // Declaration captures the accumulator including the qualifying sample
            if (declare) begin
                state_d    = ST_DEADLOCK;
                deadlock_d = 1'b1;
                irq_d      = 1'b1;
                snap_d     = acc_d;
                dtime_d    = ts_q;
                evt_d      = evt_inc;
            end
        end
    end

    // State and report registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ts_q       <= '0;
            acc_q      <= '0;
            cycles_q   <= '0;
            deadlock_q <= 1'b0;
            irq_q      <= 1'b0;
            snap_q     <= '0;
            dtime_q    <= '0;
            evt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            acc_q      <= acc_d;
            cycles_q   <= cycles_d;
            deadlock_q <= deadlock_d;
            irq_q      <= irq_d;
            snap_q     <= snap_d;
            dtime_q    <= dtime_d;
            evt_q      <= evt_d;
        end
    end

    assign deadlock       = deadlock_q;
    assign irq            = irq_q;
    assign block_snapshot = snap_q;
    assign deadlock_time  = dtime_q;
    assign block_cycles   = cycles_q;
    assign event_count    = evt_q;

endmodule

// File: tb/tb_data_proc_hls_deadlock_reporter.sv
// Bench for data_proc_hls_deadlock_reporter: a vector table with a scoreboard
// queue on the default-width instance, plus hand-written sequences on a
// narrow instance for saturation and on both for asynchronous reset.
module tb_data_proc_hls_deadlock_reporter;

    logic        clock = 1'b0;
    logic        reset_n;

    // Default-width instance
    logic        block;
    logic [2:0]  axis_block_sigs;
    logic [15:0] threshold;
    logic        clear;
    logic        deadlock;
    logic        irq;
    logic [2:0]  block_snapshot;
    logic [31:0] deadlock_time;
    logic [15:0] block_cycles;
    logic [7:0]  event_count;

    // Narrow instance for saturation
    logic        s_block;
    logic [2:0]  s_axis;
    logic [3:0]  s_thr;
    logic        s_clear;
    logic        s_dl;
    logic        s_irq;
    logic [2:0]  s_snap;
    logic [7:0]  s_time;
    logic [3:0]  s_cyc;
    logic [1:0]  s_evt;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    data_proc_hls_deadlock_reporter #(
        .AXIS_W(3), .CNT_W(16), .TS_W(32), .EVT_W(8)
    ) dut (
        .clock(clock), .reset_n(reset_n), .block(block),
        .axis_block_sigs(axis_block_sigs), .threshold(threshold), .clear(clear),
        .deadlock(deadlock), .irq(irq), .block_snapshot(block_snapshot),
        .deadlock_time(deadlock_time), .block_cycles(block_cycles),
        .event_count(event_count)
    );

    data_proc_hls_deadlock_reporter #(
        .AXIS_W(3), .CNT_W(4), .TS_W(8), .EVT_W(2)
    ) dut_s (
        .clock(clock), .reset_n(reset_n), .block(s_block),
        .axis_block_sigs(s_axis), .threshold(s_thr), .clear(s_clear),
        .deadlock(s_dl), .irq(s_irq), .block_snapshot(s_snap),
        .deadlock_time(s_time), .block_cycles(s_cyc),
        .event_count(s_evt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        blk;
        logic [2:0]  ax;
        logic [15:0] thr;
        logic        clr;
        logic        dl;
        logic        irq;
        logic [2:0]  snap;
        logic [31:0] tm;
        logic [15:0] cyc;
        logic [7:0]  evt;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic blk, input logic [2:0] ax, input logic [15:0] thr,
                       input logic clr, input logic dl, input logic ir,
                       input logic [2:0] snap, input logic [31:0] tm,
                       input logic [15:0] cyc, input logic [7:0] evt);
        vec_t v;
        v.blk = blk; v.ax = ax; v.thr = thr; v.clr = clr;
        v.dl = dl; v.irq = ir; v.snap = snap; v.tm = tm; v.cyc = cyc; v.evt = evt;
        vecs.push_back(v);
    endtask

    task automatic chk_main_zero(input string tag);
        chk({tag, ".deadlock"}, 32'(deadlock), 32'd0);
        chk({tag, ".irq"},      32'(irq), 32'd0);
        chk({tag, ".snapshot"}, 32'(block_snapshot), 32'd0);
        chk({tag, ".time"},     deadlock_time, 32'd0);
        chk({tag, ".cycles"},   32'(block_cycles), 32'd0);
        chk({tag, ".events"},   32'(event_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t cur;
        int   first_k;
        int   irq_n;

        reset_n = 1'b0;
        block = 1'b0; axis_block_sigs = '0; threshold = '0; clear = 1'b0;
        s_block = 1'b0; s_axis = '0; s_thr = '0; s_clear = 1'b0;

        //   blk  axis    thr  clr | dl irq snap    time cyc evt
        // threshold 4, three block cycles then low: no report
        add(1, 3'b001, 4, 0,   0, 0, 3'b000, 0,  1, 0);
        add(1, 3'b010, 4, 0,   0, 0, 3'b000, 0,  2, 0);
        add(1, 3'b000, 4, 0,   0, 0, 3'b000, 0,  3, 0);
        add(0, 3'b000, 4, 0,   0, 0, 3'b000, 0,  0, 0);
        add(0, 3'b000, 4, 0,   0, 0, 3'b000, 0,  0, 0);
        // threshold 4, declaration on 4th sample (timestamp 8)
        add(1, 3'b001, 4, 0,   0, 0, 3'b000, 0,  1, 0);
        add(1, 3'b001, 4, 0,   0, 0, 3'b000, 0,  2, 0);
        add(1, 3'b100, 4, 0,   0, 0, 3'b000, 0,  3, 0);
        add(1, 3'b001, 4, 0,   1, 1, 3'b101, 8,  4, 1);
        add(1, 3'b010, 4, 0,   1, 0, 3'b101, 8,  5, 1);
        add(1, 3'b010, 4, 0,   1, 0, 3'b101, 8,  6, 1);
        add(0, 3'b000, 4, 0,   1, 0, 3'b101, 8,  0, 1);
        add(1, 3'b000, 4, 0,   1, 0, 3'b101, 8,  1, 1);
        // clear with block in DEADLOCK, then re-declare at threshold 2
        add(1, 3'b000, 4, 1,   0, 0, 3'b000, 0,  0, 1);
        add(1, 3'b010, 2, 0,   0, 0, 3'b000, 0,  1, 1);
        add(1, 3'b100, 2, 0,   1, 1, 3'b110, 15, 2, 2);
        add(0, 3'b000, 2, 0,   1, 0, 3'b110, 15, 0, 2);
        add(0, 3'b000, 2, 1,   0, 0, 3'b000, 0,  0, 2);
        // threshold 0 behaves as 1
        add(1, 3'b011, 0, 0,   1, 1, 3'b011, 18, 1, 3);
        add(0, 3'b000, 0, 0,   1, 0, 3'b011, 18, 0, 3);
        add(0, 3'b000, 0, 1,   0, 0, 3'b000, 0,  0, 3);
        // clear aborts SUSPECT, then threshold lowered below count
        add(1, 3'b001, 3, 0,   0, 0, 3'b000, 0,  1, 3);
        add(1, 3'b001, 3, 1,   0, 0, 3'b000, 0,  0, 3);
        add(1, 3'b100, 3, 0,   0, 0, 3'b000, 0,  1, 3);
        add(1, 3'b000, 3, 0,   0, 0, 3'b000, 0,  2, 3);
        add(1, 3'b010, 1, 0,   1, 1, 3'b110, 25, 3, 4);
        add(0, 3'b000, 1, 1,   0, 0, 3'b000, 0,  0, 4);
        add(0, 3'b000, 4, 0,   0, 0, 3'b000, 0,  0, 4);

        repeat (3) @(negedge clock);
        chk_main_zero("reset");
        reset_n = 1'b1;

        // Table: drive at the negedge, compare at the next one
        for (int i = 0; i < vecs.size(); i++) begin
            block           = vecs[i].blk;
            axis_block_sigs = vecs[i].ax;
            threshold       = vecs[i].thr;
            clear           = vecs[i].clr;
            exp_q.push_back(vecs[i]);
            @(negedge clock);
            cur = exp_q.pop_front();
            chk($sformatf("v%0d.deadlock", i), 32'(deadlock), 32'(cur.dl));
            chk($sformatf("v%0d.irq", i),      32'(irq), 32'(cur.irq));
            chk($sformatf("v%0d.snapshot", i), 32'(block_snapshot), 32'(cur.snap));
            chk($sformatf("v%0d.time", i),     deadlock_time, cur.tm);
            chk($sformatf("v%0d.cycles", i),   32'(block_cycles), 32'(cur.cyc));
            chk($sformatf("v%0d.events", i),   32'(event_count), 32'(cur.evt));
        end
        block = 1'b0; clear = 1'b0;

        // Narrow instance: count saturation at 15 with a single irq
        s_thr = 4'd15; s_block = 1'b1; s_axis = 3'b001;
        first_k = -1; irq_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (s_irq) begin
                irq_n++;
                if (first_k < 0) first_k = k;
            end
        end
        chk("sat.cycles",    32'(s_cyc), 32'd15);
        chk("sat.irq_count", 32'(irq_n), 32'd1);
        chk("sat.irq_cycle", 32'(first_k), 32'd14);
        chk("sat.deadlock",  32'(s_dl), 32'd1);
        chk("sat.events",    32'(s_evt), 32'd1);
        s_block = 1'b0; s_clear = 1'b1;
        @(negedge clock);
        s_clear = 1'b0;
        chk("sat.clr_deadlock", 32'(s_dl), 32'd0);
        chk("sat.clr_cycles",   32'(s_cyc), 32'd0);
        chk("sat.clr_events",   32'(s_evt), 32'd1);

        // Narrow instance: event counter saturates at 3
        for (int e = 2; e <= 6; e++) begin
            s_thr = 4'd0; s_block = 1'b1;
            @(negedge clock);
            s_block = 1'b0;
            chk($sformatf("evt%0d.irq", e),    32'(s_irq), 32'd1);
            chk($sformatf("evt%0d.events", e), 32'(s_evt), (e > 3) ? 32'd3 : 32'(e));
            s_clear = 1'b1;
            @(negedge clock);
            s_clear = 1'b0;
        end

        // Asynchronous reset in the middle of SUSPECT
        threshold = 16'd4; block = 1'b1; axis_block_sigs = 3'b010;
        @(negedge clock);
        @(negedge clock);
        chk("pre_rst.cycles", 32'(block_cycles), 32'd2);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk_main_zero("rst_suspect");
        chk("rst_suspect.s_events", 32'(s_evt), 32'd0);

        // Timestamp restarts from 0 after release: declare at the 4th cycle
        @(negedge clock);
        reset_n = 1'b1; block = 1'b0;
        repeat (3) @(negedge clock);
        threshold = 16'd0; block = 1'b1; axis_block_sigs = 3'b100;
        @(negedge clock);
        block = 1'b0;
        chk("post_rst.deadlock", 32'(deadlock), 32'd1);
        chk("post_rst.irq",      32'(irq), 32'd1);
        chk("post_rst.time",     deadlock_time, 32'd3);
        chk("post_rst.snapshot", 32'(block_snapshot), 32'd4);
        chk("post_rst.events",   32'(event_count), 32'd1);

        // Asynchronous reset during DEADLOCK
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk_main_zero("rst_deadlock");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
